sv12_lrm_p0050_circ_to_radius: RTL and testbench

- Inverse of the continuous-assignment circumference expression (circ = 2.0 * PI * R): recovers radius R from a circumference value.
- Computes R = circ / TWO_PI in unsigned fixed point using a sequential restoring divider, one quotient bit per clock.
- Valid/ready handshake on input and output. Sits beside the circumference producer in the same datapath.

---
 rtl/sv12_lrm_p0050_circ_to_radius.sv | 143 ++++++++++++++
 tb/tb_sv12_lrm_p0050_circ_to_radius.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sv12_lrm_p0050_circ_to_radius.sv
// Circumference-to-radius converter: r = circ / TWO_PI in unsigned fixed point.
// Sequential restoring divider retiring one quotient bit per clock, with
// valid/ready handshakes on both the operand and result sides.
module sv12_lrm_p0050_circ_to_radius #(
    parameter int unsigned    W      = 16,
    parameter int unsigned    FRAC   = 8,
    parameter logic [W-1:0]   TWO_PI = W'(16'h0648)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] circ_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] r_o,
    output logic [W-1:0] rem_o,
    output logic         ovf_o
);

    localparam int unsigned QW = W + FRAC;
    localparam int unsigned CW = (QW > 1) ? $clog2(QW) : 1;

    // A zero divisor has no meaningful result; refuse to elaborate.
    if (TWO_PI == '0) begin : g_bad_two_pi
        $error("TWO_PI must be nonzero");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   dvd_q, dvd_d;
    logic [W-1:0]    prem_q, prem_d;
    // Holds the first QW-1 quotient bits; the last bit joins them at the final edge.
    logic [QW-2:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    r_q, r_d;
    logic [W-1:0]    rem_q, rem_d;
    logic            ovf_q, ovf_d;

    logic [W:0]      rem_shift;
    logic [W-1:0]    rem_sub;
    logic            take;
    logic [QW-1:0]   quo_next;
    logic            quo_hi;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            prem_q      <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            r_q         <= r_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, divider step and registered-output logic.
    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        r_d         = r_q;
        rem_d       = rem_q;
        ovf_d       = ovf_q;

        rem_shift = {prem_q, dvd_q[QW-1]};
        take      = (rem_shift >= {1'b0, TWO_PI});
        rem_sub   = W'(rem_shift - {1'b0, TWO_PI});
        quo_next  = {quo_q, take};
        quo_hi    = |quo_next[QW-1:W];

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    dvd_d      = {circ_i, {FRAC{1'b0}}};
                    prem_d     = '0;
                    quo_d      = '0;
                    cnt_d      = CW'(QW - 1);
                    in_ready_d = 1'b0;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d  = {dvd_q[QW-2:0], 1'b0};
                prem_d = take ? rem_sub : W'(rem_shift);
                quo_d  = quo_next[QW-2:0];
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    r_d         = quo_hi ? '1 : quo_next[W-1:0];
                    ovf_d       = quo_hi;
                    rem_d       = take ? rem_sub : W'(rem_shift);
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign r_o       = r_q;
    assign rem_o     = rem_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_sv12_lrm_p0050_circ_to_radius.sv
// Bench for the circumference-to-radius divider: arithmetic/handshake model
// checked every cycle, plus hand-computed literal results per operation.
module tb_sv12_lrm_p0050_circ_to_radius;

    localparam int unsigned W    = 16;
    localparam int unsigned FRAC = 8;
    localparam longint unsigned TP = 1608;
    localparam int LAT = 24;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] circ_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r_o;
    logic [15:0] rem_o;
    logic        ovf_o;

    logic        ov_in_valid;
    logic        ov_in_ready;
    logic [15:0] ov_circ_i;
    logic        ov_out_valid;
    logic        ov_out_ready;
    logic [15:0] ov_r_o;
    logic [15:0] ov_rem_o;
    logic        ov_ovf_o;

    int checks;
    int failures;
    int cyc;

    sv12_lrm_p0050_circ_to_radius dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .circ_i(circ_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_o(r_o), .rem_o(rem_o), .ovf_o(ovf_o)
    );

    sv12_lrm_p0050_circ_to_radius #(.W(16), .FRAC(8), .TWO_PI(16'h0080)) dut_ov (
        .clk(clk), .rst_n(rst_n),
        .in_valid(ov_in_valid), .in_ready(ov_in_ready), .circ_i(ov_circ_i),
        .out_valid(ov_out_valid), .out_ready(ov_out_ready),
        .r_o(ov_r_o), .rem_o(ov_rem_o), .ovf_o(ov_ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: accept -> result appears LAT edges later, held until taken.
    logic        m_rdy, m_busy, m_vld, m_ovf;
    int          m_left;
    logic [15:0] m_r, m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy = 1'b0; m_busy = 1'b0; m_vld = 1'b0; m_left = 0;
            m_r = '0; m_rem = '0; m_ovf = 1'b0;
        end else if (m_vld) begin
            if (out_ready) begin
                m_vld = 1'b0;
                m_rdy = 1'b1;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_vld  = 1'b1;
            end
        end else begin
            if (in_valid && m_rdy) begin
                longint unsigned dv, q;
                dv = longint'(circ_i) << FRAC;
                q  = dv / TP;
                m_rem = 16'(dv % TP);
                if (q > 64'hFFFF) begin
                    m_r = 16'hFFFF; m_ovf = 1'b1;
                end else begin
                    m_r = 16'(q); m_ovf = 1'b0;
                end
                m_busy = 1'b1;
                m_left = LAT;
                m_rdy  = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("cmp_in_ready", 32'(in_ready), 32'(m_rdy));
        chk("cmp_out_valid", 32'(out_valid), 32'(m_vld));
        if (m_vld && out_valid) begin
            chk("cmp_r", 32'(r_o), 32'(m_r));
            chk("cmp_rem", 32'(rem_o), 32'(m_rem));
            chk("cmp_ovf", 32'(ovf_o), 32'(m_ovf));
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // One operation with literal expectations; hold>0 stalls the result that many cycles.
    task automatic do_op(input string nm, input logic [15:0] c, input int hold,
                         input logic [15:0] er, input logic [15:0] erem, input logic eovf);
        int acc;
        int n;
        wait_ready(nm);
        out_ready = (hold == 0);
        circ_i    = c;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        acc      = cyc;
        in_valid = 1'b0;
        circ_i   = 16'($urandom);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "_latency"}, 32'(cyc - acc), 32'(LAT));
        chk({nm, "_r"}, 32'(r_o), 32'(er));
        chk({nm, "_rem"}, 32'(rem_o), 32'(erem));
        chk({nm, "_ovf"}, 32'(ovf_o), 32'(eovf));
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            circ_i   = 16'($urandom);
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_hold_r"}, 32'(r_o), 32'(er));
            chk({nm, "_hold_rem"}, 32'(rem_o), 32'(erem));
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_back_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; circ_i = '0;
        ov_in_valid = 1'b0; ov_out_ready = 1'b1; ov_circ_i = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_r", 32'(r_o), 32'd0);
        chk("rst_rem", 32'(rem_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("rel_in_ready_high", 32'(in_ready), 32'd1);

        do_op("two_pi", 16'h0648, 0, 16'h0100, 16'h0000, 1'b0);
        do_op("pi", 16'h0324, 0, 16'h0080, 16'h0000, 1'b0);
        do_op("zero", 16'h0000, 0, 16'h0000, 16'h0000, 1'b0);
        do_op("max", 16'hFFFF, 0, 16'h28C1, 16'h02B8, 1'b0);
        do_op("stall", 16'h0C90, 10, 16'h0200, 16'h0000, 1'b0);

        // Overflow with a scale factor below one.
        n = 0;
        while (!ov_in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ov_ready", 32'(ov_in_ready), 32'd1);
        ov_circ_i = 16'h8000; ov_in_valid = 1'b1;
        @(posedge clk); #1;
        ov_in_valid = 1'b0;
        n = 0;
        while (!ov_out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ov_valid", 32'(ov_out_valid), 32'd1);
        chk("ov_r", 32'(ov_r_o), 32'hFFFF);
        chk("ov_ovf", 32'(ov_ovf_o), 32'd1);
        chk("ov_rem", 32'(ov_rem_o), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a calculation.
        wait_ready("abort");
        circ_i = 16'h1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        chk("abort_r", 32'(r_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_in_ready_held", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready_back", 32'(in_ready), 32'd1);
        do_op("after_abort", 16'h0648, 0, 16'h0100, 16'h0000, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
